// File: rtl/qu_common.sv
// Shared front-end types and constants.
// Holds the PC width/reset value, redirect cause and front_ctrl state enums.
package qu_common;

   localparam int QU_PC_WIDTH = 32;

   localparam logic [QU_PC_WIDTH-1:0] QU_PC_RESET_VAL = 32'h0000_1000;

   typedef enum logic [1:0] {
      RC_NONE      = 2'd0,
      RC_BRANCH    = 2'd1,
      RC_JUMP      = 2'd2,
      RC_EXCEPTION = 2'd3
   } redirect_cause_t;

   typedef enum logic [1:0] {
      FC_RESET  = 2'd0,
      FC_WARMUP = 2'd1,
      FC_FLUSH  = 2'd2,
      FC_RUN    = 2'd3
   } front_ctrl_state_t;

   // Requests may overlap; the most severe one names the redirect.
   function automatic redirect_cause_t pick_cause(
      input logic br,
      input logic jp,
      input logic ex
   );
      if (ex) begin
         return RC_EXCEPTION;
      end else if (jp) begin
         return RC_JUMP;
      end else if (br) begin
         return RC_BRANCH;
      end
      return RC_NONE;
   endfunction

endpackage

// File: rtl/front_ctrl.sv
// Front-end pipeline controller: startup warmup, redirect flush, stalls.
// Ports: clk/rst, branch/jump/exception + pc_override requests, stall,
// stage_stall; drives stage_en, fifo_flush, redirect_valid/pc/cause,
// busy and a saturating redirect_count.
module front_ctrl
   import qu_common::*;
#(
   parameter int N_STAGES     = 4,
   parameter int PC_WIDTH     = QU_PC_WIDTH,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                branch,
   input  logic                jump,
   input  logic                exception,
   input  logic [PC_WIDTH-1:0] pc_override,
   input  logic                stall,
   input  logic [N_STAGES-1:0] stage_stall,
   output logic [N_STAGES-1:0] stage_en,
   output logic [N_STAGES-2:0] fifo_flush,
   output logic                redirect_valid,
   output logic [PC_WIDTH-1:0] redirect_pc,
   output redirect_cause_t     redirect_cause,
   output logic                busy,
   output logic [15:0]         redirect_count
);

   localparam int WW = (N_STAGES > 2) ? $clog2(N_STAGES) : 1;
   localparam logic [WW-1:0] W_LAST = WW'(N_STAGES - 1);
   localparam logic [3:0] F_LAST = 4'(FLUSH_CYCLES - 1);

   front_ctrl_state_t state;
   front_ctrl_state_t state_nxt;

   logic [WW-1:0]       w;
   logic [3:0]          fcnt;
   logic                accept;
   logic [N_STAGES-1:0] active;
   logic [N_STAGES-1:0] blocked;
   logic                blk_acc;

   // Requests are ignored in RESET and on any edge where rst is high.
   assign accept = (branch | jump | exception)
                 & ~rst
                 & (state != FC_RESET);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FC_RESET;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         FC_RESET: begin
            state_nxt = FC_WARMUP;
         end
         FC_WARMUP: begin
            if (accept) begin
               state_nxt = FC_FLUSH;
            end else if (!stall && w == W_LAST) begin
               state_nxt = FC_RUN;
            end
         end
         FC_FLUSH: begin
            if (accept) begin
               state_nxt = FC_FLUSH;
            end else if (fcnt == F_LAST) begin
               state_nxt = FC_WARMUP;
            end
         end
         FC_RUN: begin
            if (accept) begin
               state_nxt = FC_FLUSH;
            end
         end
         default: begin
            state_nxt = FC_RESET;
         end
      endcase
   end

   // w only advances while staying in WARMUP; any other path clears it.
   // fcnt restarts on every accepted redirect, stall does not freeze it.
   always_ff @(posedge clk) begin
      if (rst) begin
         w    <= '0;
         fcnt <= '0;
      end else begin
         if (state == FC_WARMUP && state_nxt == FC_WARMUP) begin
            if (!stall) begin
               w <= w + 1'b1;
            end
         end else begin
            w <= '0;
         end
         if (state == FC_FLUSH && state_nxt == FC_FLUSH && !accept) begin
            fcnt <= fcnt + 1'b1;
         end else begin
            fcnt <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_valid <= 1'b0;
         fifo_flush     <= '1;
         redirect_pc    <= PC_WIDTH'(QU_PC_RESET_VAL);
         redirect_cause <= RC_NONE;
         redirect_count <= '0;
      end else begin
         redirect_valid <= accept;
         fifo_flush     <= {(N_STAGES-1){accept}};
         if (accept) begin
            redirect_pc    <= pc_override;
            redirect_cause <= pick_cause(branch, jump, exception);
            if (redirect_count != 16'hFFFF) begin
               redirect_count <= redirect_count + 16'd1;
            end
         end
      end
   end

   // A stall at stage j holds back every stage upstream of it too.
   always_comb begin
      active  = '0;
      blocked = '0;
      blk_acc = stall;
      for (int k = N_STAGES - 1; k >= 0; k--) begin
         blk_acc    = blk_acc | stage_stall[k];
         blocked[k] = blk_acc;
      end
      unique case (state)
         FC_RUN: begin
            active = '1;
         end
         FC_WARMUP: begin
            for (int k = 0; k < N_STAGES; k++) begin
               active[k] = (k <= int'(w));
            end
         end
         default: begin
            active = '0;
         end
      endcase
      stage_en = active & ~blocked;
      busy     = (state != FC_RUN);
   end

endmodule

// File: tb/tb_front_ctrl.sv
// Directed scoreboard bench for front_ctrl with N_STAGES=4, FLUSH_CYCLES=2.
// Expected output snapshots are queued before each edge and checked after.
module tb_front_ctrl;
   import qu_common::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        branch;
   logic        jump;
   logic        exception;
   logic [31:0] pc_override;
   logic        stall;
   logic [3:0]  stage_stall;
   logic [3:0]  stage_en;
   logic [2:0]  fifo_flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   redirect_cause_t redirect_cause;
   logic        busy;
   logic [15:0] redirect_count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       tag;
      logic [3:0]  en;
      logic [2:0]  ff;
      logic        rv;
      logic [31:0] pc;
      logic [1:0]  cause;
      logic        bsy;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];

   localparam logic [31:0] RST_PC = 32'h0000_1000;

   front_ctrl #(
      .N_STAGES    (4),
      .PC_WIDTH    (32),
      .FLUSH_CYCLES(2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .branch        (branch),
      .jump          (jump),
      .exception     (exception),
      .pc_override   (pc_override),
      .stall         (stall),
      .stage_stall   (stage_stall),
      .stage_en      (stage_en),
      .fifo_flush    (fifo_flush),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .redirect_cause(redirect_cause),
      .busy          (busy),
      .redirect_count(redirect_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [3:0] en,
                       input logic [2:0] ff, input logic rv,
                       input logic [31:0] pc, input logic [1:0] cause,
                       input logic bsy, input logic [15:0] cnt);
      exp_t e;
      e.tag = tag; e.en = en; e.ff = ff; e.rv = rv;
      e.pc = pc; e.cause = cause; e.bsy = bsy; e.cnt = cnt;
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      checks++;
      assert (sb.size() > 0) else begin
         errors++;
         $error("FAIL sb_empty: observed 0 expected >0 entries");
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({e.tag, ".stage_en"}, 32'(stage_en), 32'(e.en));
         chk({e.tag, ".fifo_flush"}, 32'(fifo_flush), 32'(e.ff));
         chk({e.tag, ".rv"}, 32'(redirect_valid), 32'(e.rv));
         chk({e.tag, ".pc"}, redirect_pc, e.pc);
         chk({e.tag, ".cause"}, 32'(redirect_cause), 32'(e.cause));
         chk({e.tag, ".busy"}, 32'(busy), 32'(e.bsy));
         chk({e.tag, ".count"}, 32'(redirect_count), 32'(e.cnt));
      end
   endtask

   // Queue the expected post-edge snapshot, clock once, then compare.
   task automatic cyc(input string tag, input logic [3:0] en,
                      input logic [2:0] ff, input logic rv,
                      input logic [31:0] pc, input logic [1:0] cause,
                      input logic bsy, input logic [15:0] cnt);
      push(tag, en, ff, rv, pc, cause, bsy, cnt);
      @(posedge clk);
      #1;
      pop_check();
   endtask

   initial begin
      rst = 1'b1; branch = 1'b0; jump = 1'b0; exception = 1'b0;
      pc_override = '0; stall = 1'b0; stage_stall = '0;

      cyc("rst0", 4'b0000, 3'b111, 0, RST_PC, 2'd0, 1, 16'd0);
      cyc("rst1", 4'b0000, 3'b111, 0, RST_PC, 2'd0, 1, 16'd0);

      rst = 1'b0;
      cyc("wu1", 4'b0001, 3'b000, 0, RST_PC, 2'd0, 1, 16'd0);
      cyc("wu2", 4'b0011, 3'b000, 0, RST_PC, 2'd0, 1, 16'd0);
      cyc("wu3", 4'b0111, 3'b000, 0, RST_PC, 2'd0, 1, 16'd0);
      cyc("wu4", 4'b1111, 3'b000, 0, RST_PC, 2'd0, 1, 16'd0);
      cyc("run", 4'b1111, 3'b000, 0, RST_PC, 2'd0, 0, 16'd0);

      stage_stall = 4'b0100;
      cyc("sstall", 4'b1000, 3'b000, 0, RST_PC, 2'd0, 0, 16'd0);
      stage_stall = 4'b0000;

      branch = 1'b1; pc_override = 32'h100;
      cyc("br_f0", 4'b0000, 3'b111, 1, 32'h100, 2'd1, 1, 16'd1);
      branch = 1'b0; pc_override = 32'hdead;
      cyc("br_f1", 4'b0000, 3'b000, 0, 32'h100, 2'd1, 1, 16'd1);
      cyc("br_w0", 4'b0001, 3'b000, 0, 32'h100, 2'd1, 1, 16'd1);
      cyc("br_w1", 4'b0011, 3'b000, 0, 32'h100, 2'd1, 1, 16'd1);

      stall = 1'b1;
      #1;
      chk("stall_now", 32'(stage_en), 32'h0);
      cyc("st_a", 4'b0000, 3'b000, 0, 32'h100, 2'd1, 1, 16'd1);
      cyc("st_b", 4'b0000, 3'b000, 0, 32'h100, 2'd1, 1, 16'd1);
      stall = 1'b0;
      #1;
      chk("w_held", 32'(stage_en), 32'h3);
      cyc("st_w2", 4'b0111, 3'b000, 0, 32'h100, 2'd1, 1, 16'd1);
      cyc("st_w3", 4'b1111, 3'b000, 0, 32'h100, 2'd1, 1, 16'd1);
      cyc("st_run", 4'b1111, 3'b000, 0, 32'h100, 2'd1, 0, 16'd1);

      branch = 1'b1; jump = 1'b1; exception = 1'b1;
      pc_override = 32'h200;
      cyc("ex_f0", 4'b0000, 3'b111, 1, 32'h200, 2'd3, 1, 16'd2);
      branch = 1'b0; exception = 1'b0;
      pc_override = 32'h300;
      cyc("re_f0", 4'b0000, 3'b111, 1, 32'h300, 2'd2, 1, 16'd3);
      jump = 1'b0; pc_override = 32'h0;
      cyc("re_f1", 4'b0000, 3'b000, 0, 32'h300, 2'd2, 1, 16'd3);
      cyc("re_w0", 4'b0001, 3'b000, 0, 32'h300, 2'd2, 1, 16'd3);
      cyc("re_w1", 4'b0011, 3'b000, 0, 32'h300, 2'd2, 1, 16'd3);

      branch = 1'b1; pc_override = 32'h400;
      cyc("wbr_f0", 4'b0000, 3'b111, 1, 32'h400, 2'd1, 1, 16'd4);
      branch = 1'b0;
      rst = 1'b1; exception = 1'b1; pc_override = 32'h500;
      cyc("rst_fl", 4'b0000, 3'b111, 0, RST_PC, 2'd0, 1, 16'd0);
      rst = 1'b0; exception = 1'b0;
      cyc("rst_w0", 4'b0001, 3'b000, 0, RST_PC, 2'd0, 1, 16'd0);

      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
